add_some_bitz_arb: RTL and testbench
====================================

ADD_SOME_BITZ_ARB -- requirements
Module: add_some_bitz_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning the byte address width of the register block (4 x 32-bit registers).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the register and AXI4-Lite data width.
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
- ACLK  in  1  sole clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- REQ_VALID  in  2  request pending, one bit per requester [i].
- REQ_WRITE  in  2  1 = write, 0 = read, per requester.
- REQ_ADDR  in  2*ADDR_WIDTH  byte address; slice [i] belongs to requester i.
- REQ_WDATA  in  2*DATA_WIDTH  write data; slice [i] belongs to requester i.
- REQ_READY  out  2  one-cycle accept pulse to the granted requester.
- RSP_VALID  out  2  one-cycle completion pulse to the owning requester.
- RSP_RDATA  out  DATA_WIDTH  read data, valid with RSP_VALID.
- RSP_ERR  out  1  1 = slave returned RESP != OKAY, valid with RSP_VALID.
- M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID  out  ADDR_WIDTH, 3, 1  AXI4-Lite write address channel; M_AXI_AWREADY  in  1.
- M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID  out  DATA_WIDTH, DATA_WIDTH/8, 1  write data channel; M_AXI_WREADY  in  1.
- M_AXI_BRESP, M_AXI_BVALID  in  2, 1  write response channel; M_AXI_BREADY  out  1.
- M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID  out  ADDR_WIDTH, 3, 1  read address channel; M_AXI_ARREADY  in  1.
- M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID  in  DATA_WIDTH, 2, 1  read data channel; M_AXI_RREADY  out  1.

Function
REQ-004 SHALL implement the FSM states IDLE, ISSUE, WAIT_RSP and DONE, with at most one outstanding AXI transaction.
REQ-005 In IDLE with any REQ_VALID set, the block SHALL grant one requester, pulse its REQ_READY for one cycle, register its WRITE/ADDR/WDATA, and move to ISSUE.
REQ-006 Arbitration SHALL be round-robin: a priority pointer (reset 0) SHALL favour requester ptr and SHALL flip to the other requester after each grant; a lone requester SHALL be granted regardless of the pointer.
REQ-007 In ISSUE for a write, AWVALID and WVALID SHALL assert in the same cycle, and each SHALL deassert independently in the cycle after its own handshake; the FSM SHALL go to WAIT_RSP once both handshakes are done, in either order or simultaneously.
REQ-008 In ISSUE for a read, ARVALID SHALL assert until ARREADY, then the FSM SHALL go to WAIT_RSP.
REQ-009 AWADDR/ARADDR SHALL carry the registered address, WSTRB SHALL be all ones, and AWPROT/ARPROT SHALL be 3'b000.
REQ-010 Addresses, data and valids SHALL stay stable while a VALID is high and not yet accepted.
REQ-011 In WAIT_RSP, BREADY (write) or RREADY (read) SHALL be held high; on BVALID/RVALID the block SHALL capture RDATA (read) and RSP_ERR = (RESP != 2'b00), then go to DONE.
REQ-012 In DONE, the block SHALL pulse RSP_VALID[owner] for one cycle and return to IDLE; a new grant SHALL be possible in the following cycle.
REQ-013 Minimum latency with zero-wait slave readiness SHALL be REQ_READY at cycle 0, address/data VALID at cycle 1, response at cycle 2, and RSP_VALID at cycle 3.
REQ-014 REQ_VALID changes while the FSM is not in IDLE SHALL be ignored until the FSM returns to IDLE; requests are not queued.
REQ-015 RSP_RDATA SHALL hold its last value between responses and SHALL be 0 for writes.

Reset
REQ-016 On ARESETN low, the block SHALL asynchronously force: FSM to IDLE, pointer to 0, and all VALID, READY, REQ_READY, RSP_VALID, RSP_ERR and RSP_RDATA outputs to 0.
REQ-017 A reset during ISSUE or WAIT_RSP SHALL abandon the transaction with no RSP_VALID; after release, the block SHALL resume arbitration from IDLE.

Configuration
REQ-018 With ADD_SOME_BITZ_ARB_STATS_EN defined, the block SHALL add outputs GRANT_CNT0 and GRANT_CNT1 (16 bits each, out), which count grants per requester, saturate at 0xFFFF and reset to 0.
REQ-019 Without ADD_SOME_BITZ_ARB_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-020 R0 writes 0x00000001 to 0x0, then R0 reads 0x0 -> AWADDR=0x0, WDATA=0x1, then RSP_RDATA=0x00000001 with RSP_ERR=0, and REQ_READY-to-RSP_VALID = 3 cycles.
REQ-021 R0 and R1 assert simultaneously and continuously from reset (R0 writes 0x4, R1 writes 0x8) -> grants R0, R1, R0, R1, with AWADDR alternating 0x4/0x8.
REQ-022 Slave holds AWREADY low 5 cycles while WREADY is immediate -> WVALID drops after 1 cycle, AWVALID holds 6 cycles, and exactly one B handshake and one RSP_VALID occur.
REQ-023 Slave returns RRESP=2'b10 to an R1 read of 0xC -> RSP_VALID[1]=1 with RSP_ERR=1, and the next OKAY response clears RSP_ERR.
REQ-024 ARESETN is pulled low while in WAIT_RSP -> all outputs are 0 immediately, no RSP_VALID is produced, and a post-reset R1 request is granted first (pointer=0 with only R1 requesting).
REQ-025 With ADD_SOME_BITZ_ARB_STATS_EN, run 3 R0 and 2 R1 transactions -> GRANT_CNT0=3 and GRANT_CNT1=2.

Source files
------------

// File: rtl/add_some_bitz_arb.sv
// Two-requester round-robin front end onto a single AXI4-Lite master port, one transaction in flight.
// Optional per-requester grant counters when ADD_SOME_BITZ_ARB_STATS_EN is defined.
module add_some_bitz_arb #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [1:0]                REQ_VALID,
    input  logic [1:0]                REQ_WRITE,
    input  logic [2*ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [2*DATA_WIDTH-1:0]   REQ_WDATA,
    output logic [1:0]                REQ_READY,
    output logic [1:0]                RSP_VALID,
    output logic [DATA_WIDTH-1:0]     RSP_RDATA,
    output logic                      RSP_ERR,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
`ifdef ADD_SOME_BITZ_ARB_STATS_EN
    ,
    output logic [15:0]               GRANT_CNT0,
    output logic [15:0]               GRANT_CNT1
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  owner_q, owner_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic gnt_any;
    logic gnt_idx;
    logic grant;
    logic aw_hs, w_hs;

    assign gnt_any = |REQ_VALID;
    // Pointer only matters when both request; a lone requester always wins.
    assign gnt_idx = (REQ_VALID == 2'b11) ? ptr_q : REQ_VALID[1];
    assign grant   = (state_q == S_IDLE) && gnt_any;
    assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_any) begin
                    owner_d   = gnt_idx;
                    ptr_d     = ~gnt_idx;
                    write_d   = REQ_WRITE[gnt_idx];
                    addr_d    = gnt_idx ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                        : REQ_ADDR[ADDR_WIDTH-1:0];
                    wdata_d   = gnt_idx ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH]
                                        : REQ_WDATA[DATA_WIDTH-1:0];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (write_q) begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                    if (aw_done_d && w_done_d) state_d = S_WAIT;
                end else if (M_AXI_ARREADY) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (write_q && M_AXI_BVALID) begin
                    err_d   = (M_AXI_BRESP != 2'b00);
                    rdata_d = '0;
                    state_d = S_DONE;
                end else if (!write_q && M_AXI_RVALID) begin
                    err_d   = (M_AXI_RRESP != 2'b00);
                    rdata_d = M_AXI_RDATA;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // REQ_READY is a decode of live inputs, so it is gated to stay low while reset is held.
    assign REQ_READY     = (grant && ARESETN) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    assign RSP_VALID     = (state_q == S_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign RSP_RDATA     = rdata_q;
    assign RSP_ERR       = err_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (state_q == S_ISSUE) && write_q && !aw_done_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = (state_q == S_ISSUE) && write_q && !w_done_q;
    assign M_AXI_BREADY  = (state_q == S_WAIT) && write_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state_q == S_ISSUE) && !write_q;
    assign M_AXI_RREADY  = (state_q == S_WAIT) && !write_q;

`ifdef ADD_SOME_BITZ_ARB_STATS_EN
    logic [15:0] gcnt0_q, gcnt0_d;
    logic [15:0] gcnt1_q, gcnt1_d;

    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (grant && !gnt_idx && (gcnt0_q != 16'hFFFF)) gcnt0_d = gcnt0_q + 16'd1;
        if (grant && gnt_idx && (gcnt1_q != 16'hFFFF))  gcnt1_d = gcnt1_q + 16'd1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign GRANT_CNT0 = gcnt0_q;
    assign GRANT_CNT1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_add_some_bitz_arb.sv
// Bench for add_some_bitz_arb: behavioural AXI4-Lite register slave plus a transaction-level
// model of arbitration, register contents, response data/error and latency.
module tb_add_some_bitz_arb;

    logic        ACLK;
    logic        ARESETN;
    logic [1:0]  REQ_VALID, REQ_WRITE;
    logic [7:0]  REQ_ADDR;
    logic [63:0] REQ_WDATA;
    logic [1:0]  REQ_READY, RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
`ifdef ADD_SOME_BITZ_ARB_STATS_EN
    logic [15:0] GRANT_CNT0, GRANT_CNT1;
`endif

    add_some_bitz_arb #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
`ifdef ADD_SOME_BITZ_ARB_STATS_EN
        , .GRANT_CNT0(GRANT_CNT0), .GRANT_CNT1(GRANT_CNT1)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int errs = 0;
    int checks = 0;

    // slave knobs and observations
    int          aw_cnt, w_cnt, ar_cnt, rs_cnt;
    bit          slv_err;
    int          awv_cyc, wv_cyc, bhs, rsp_pulses;
    logic        aw_got, w_got, b_pend, r_pend, b_err, r_err;
    logic        p_aw, p_w, p_b, p_ar, p_r;
    logic [3:0]  aw_a, r_a, p_awaddr, p_araddr, w_strb, p_wstrb;
    logic [31:0] w_d, p_wdata;
    logic [31:0] mem [4];

    // reference model state
    logic [31:0] mem_m [4];
    int          ptr_m;
    int          gcnt_m [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register-file slave; every decision is made on the falling edge, so a handshake
    // seen here (valid && ready) takes effect on the next rising edge.
    task automatic slave();
        forever begin
            @(negedge ACLK);
            if (RSP_VALID != 2'b00) rsp_pulses++;
            if (!ARESETN) begin
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
                M_AXI_BVALID = 0; M_AXI_RVALID = 0;
            end else begin
                if (p_aw) begin aw_got = 1; aw_a = p_awaddr; end
                if (p_w)  begin w_got = 1; w_d = p_wdata; w_strb = p_wstrb; end
                if (p_b)  begin b_pend = 0; bhs++; end
                if (p_r)  r_pend = 0;
                if (p_ar) begin r_pend = 1; r_a = p_araddr; r_err = slv_err; end
                if (aw_got && w_got) begin
                    mem[aw_a[3:2]] = w_d; b_pend = 1; b_err = slv_err; aw_got = 0; w_got = 0;
                end
                M_AXI_AWREADY = 0;
                if (M_AXI_AWVALID) begin
                    awv_cyc++;
                    if (aw_cnt > 0) aw_cnt--; else M_AXI_AWREADY = 1;
                end
                M_AXI_WREADY = 0;
                if (M_AXI_WVALID) begin
                    wv_cyc++;
                    if (w_cnt > 0) w_cnt--; else M_AXI_WREADY = 1;
                end
                M_AXI_ARREADY = 0;
                if (M_AXI_ARVALID) begin
                    if (ar_cnt > 0) ar_cnt--; else M_AXI_ARREADY = 1;
                end
                M_AXI_BVALID = 0;
                M_AXI_RVALID = 0;
                if (b_pend || r_pend) begin
                    if (rs_cnt > 0) rs_cnt--;
                    else if (b_pend) M_AXI_BVALID = 1;
                    else M_AXI_RVALID = 1;
                end
                M_AXI_BRESP = b_err ? 2'b10 : 2'b00;
                M_AXI_RRESP = r_err ? 2'b10 : 2'b00;
                M_AXI_RDATA = mem[r_a[3:2]];
                p_aw = M_AXI_AWVALID && M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
                p_w  = M_AXI_WVALID && M_AXI_WREADY;   p_wdata = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
                p_b  = M_AXI_BVALID && M_AXI_BREADY;
                p_ar = M_AXI_ARVALID && M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
                p_r  = M_AXI_RVALID && M_AXI_RREADY;
            end
        end
    endtask

    // One request round: present requests, check who wins, then check the response.
    task automatic run(input logic [1:0] v, input logic [1:0] wr, input logic [1:0] i0, input logic [1:0] i1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input int saw, input int sw, input int sar, input int srs,
                       input bit err, input bit keep);
        int g, lat, st;
        bit seen, w;
        logic [1:0] idx;
        logic [31:0] d, exp_d;
        REQ_VALID = v; REQ_WRITE = wr;
        REQ_ADDR = {i1, 2'b00, i0, 2'b00}; REQ_WDATA = {d1, d0};
        aw_cnt = saw; w_cnt = sw; ar_cnt = sar; rs_cnt = srs; slv_err = err;
        awv_cyc = 0; wv_cyc = 0; bhs = 0; rsp_pulses = 0;
        g = (v == 2'b11) ? ptr_m : (v[1] ? 1 : 0);
        w = wr[g]; idx = g ? i1 : i0; d = g ? d1 : d0;
        seen = 0;
        #1;
        for (int n = 0; n < 40; n++) begin
            if (REQ_READY != 2'b00) begin seen = 1; break; end
            @(negedge ACLK); #1;
        end
        chk("grant_seen", seen, 1);
        chk("grant", REQ_READY, g ? 2'b10 : 2'b01);
        ptr_m = g ? 0 : 1;
        gcnt_m[g]++;
        if (w) begin mem_m[idx] = d; exp_d = 0; end
        else exp_d = mem_m[idx];
        st = w ? ((saw > sw) ? saw : sw) : sar;
        seen = 0; lat = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge ACLK);
            if (!keep) REQ_VALID = 2'b00;
            #1; lat++;
            if (RSP_VALID != 2'b00) begin seen = 1; break; end
        end
        chk("rsp_seen", seen, 1);
        chk("rsp_owner", RSP_VALID, g ? 2'b10 : 2'b01);
        chk("rsp_rdata", RSP_RDATA, exp_d);
        chk("rsp_err", RSP_ERR, err);
        chk("latency", lat, 3 + st + srs);
        if (w) begin
            chk("awaddr", aw_a, {idx, 2'b00});
            chk("wdata", w_d, d);
            chk("wstrb", w_strb, 4'hF);
        end else begin
            chk("araddr", r_a, {idx, 2'b00});
        end
        @(negedge ACLK); #1;
        chk("rsp_pulse_end", RSP_VALID, 2'b00);
    endtask

    initial begin
        bit seen;
        ARESETN = 0; REQ_VALID = 2'b11; REQ_WRITE = 0; REQ_ADDR = 0; REQ_WDATA = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_BRESP = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rs_cnt = 0; slv_err = 0;
        awv_cyc = 0; wv_cyc = 0; bhs = 0; rsp_pulses = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_err = 0; r_err = 0;
        p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
        aw_a = 0; r_a = 0; p_awaddr = 0; p_araddr = 0; w_strb = 0; p_wstrb = 0; w_d = 0; p_wdata = 0;
        for (int i = 0; i < 4; i++) begin mem[i] = 0; mem_m[i] = 0; end
        ptr_m = 0; gcnt_m[0] = 0; gcnt_m[1] = 0;
        fork slave(); join_none

        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_req_ready", REQ_READY, 2'b00);
        chk("rst_rsp_valid", RSP_VALID, 2'b00);
        chk("rst_rsp_err", RSP_ERR, 0);
        chk("rst_rsp_rdata", RSP_RDATA, 0);
        chk("rst_axi_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 0);
        @(negedge ACLK);
        ARESETN = 1;

        // both requesting continuously from reset: R0 @0x4, R1 @0x8, strict alternation
        for (int k = 0; k < 4; k++)
            run(2'b11, 2'b11, 2'd1, 2'd2, 32'h1000 + k, 32'h2000 + k, 0, 0, 0, 0, 0, 1);
        REQ_VALID = 2'b00;
        @(negedge ACLK);

        // write then read back, zero-wait
        run(2'b01, 2'b01, 2'd0, 2'd0, 32'h1, 32'h0, 0, 0, 0, 0, 0, 0);
        run(2'b01, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);

        // AW held off 5 cycles, W immediate
        run(2'b01, 2'b01, 2'd2, 2'd0, 32'hA5A5_0001, 32'h0, 5, 0, 0, 0, 0, 0);
        chk("aw_valid_cycles", awv_cyc, 6);
        chk("w_valid_cycles", wv_cyc, 1);
        chk("b_handshakes", bhs, 1);
        chk("rsp_pulses", rsp_pulses, 1);

        // SLVERR on R1 read of 0xC, then an OKAY read clears the error
        run(2'b10, 2'b00, 2'd0, 2'd3, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0);
        run(2'b10, 2'b00, 2'd0, 2'd3, 32'h0, 32'h0, 0, 0, 1, 2, 0, 0);

        for (int k = 0; k < 30; k++)
            run(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), ($urandom_range(0, 7) == 0), 0);

        // leave nonzero read data behind, then reset in the middle of a read's response wait
        run(2'b01, 2'b01, 2'd1, 2'd0, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0, 0, 0);
        run(2'b01, 2'b00, 2'd1, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
        REQ_VALID = 2'b01; REQ_WRITE = 2'b00; REQ_ADDR = 8'h00; rs_cnt = 20; ar_cnt = 0; slv_err = 0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge ACLK); #1;
            if (M_AXI_RREADY) begin seen = 1; break; end
        end
        chk("reach_wait_rsp", seen, 1);
        REQ_VALID = 2'b11;
        rsp_pulses = 0;
        ARESETN = 0;
        #1;
        chk("arst_req_ready", REQ_READY, 2'b00);
        chk("arst_rsp_valid", RSP_VALID, 2'b00);
        chk("arst_rsp_err", RSP_ERR, 0);
        chk("arst_rsp_rdata", RSP_RDATA, 0);
        chk("arst_axi_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 0);
`ifdef ADD_SOME_BITZ_ARB_STATS_EN
        chk("arst_gcnt", {GRANT_CNT0, GRANT_CNT1}, 0);
`endif
        repeat (3) @(negedge ACLK);
        ARESETN = 1; REQ_VALID = 2'b00;
        repeat (3) @(negedge ACLK);
        #1;
        chk("abandoned_no_rsp", rsp_pulses, 0);
        ptr_m = 0; gcnt_m[0] = 0; gcnt_m[1] = 0;

        // after reset: both -> R0 (pointer back at 0), then 3 R0 / 2 R1 in total
        run(2'b11, 2'b00, 2'd1, 2'd2, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
        run(2'b10, 2'b10, 2'd0, 2'd3, 32'h0, 32'h55, 0, 0, 0, 0, 0, 0);
        run(2'b01, 2'b01, 2'd0, 2'd0, 32'h77, 32'h0, 0, 1, 0, 0, 0, 0);
        run(2'b10, 2'b00, 2'd0, 2'd3, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
        run(2'b01, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 0, 0, 2, 0, 0, 0);
`ifdef ADD_SOME_BITZ_ARB_STATS_EN
        chk("grant_cnt0", GRANT_CNT0, gcnt_m[0]);
        chk("grant_cnt1", GRANT_CNT1, gcnt_m[1]);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
